// File: rtl/im_arb_pkg.sv
// rtl/im_arb_pkg.sv - shared types and defaults for the instruction-memory port arbiter
//
// Purpose : port-id enum, default widths, the SRAM request record and a
//           saturating counter helper used by im_port_arbiter.
// Ports   : none (package)
package im_arb_pkg;

   localparam int IM_ADDR_W = 32;
   localparam int IM_DATA_W = 32;
   localparam int IM_STRB_W = IM_DATA_W / 8;

   typedef enum logic {
      PORT_FETCH = 1'b0,
      PORT_DATA  = 1'b1
   } port_id_e;

   // One SRAM access as presented by a requester.
   typedef struct packed {
      logic [IM_ADDR_W-1:0] addr;
      logic                 we;
      logic [IM_DATA_W-1:0] wdata;
      logic [IM_STRB_W-1:0] wstrb;
   } im_req_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/im_resp_skid.sv
// rtl/im_resp_skid.sv - per-port read response tracker with a 1-entry skid hold
//
// Purpose : tracks a read issued last cycle (inflight), captures SRAM data into a
//           hold register when the consumer stalls, and presents the response.
// Ports   : clk, rst         - clock, synchronous active-high reset
//           i_flush          - discard older responses (tie 0 when unused)
//           i_issue          - a read from this port is granted this cycle
//           i_rready         - consumer accepts the presented response
//           i_sram_rdata     - SRAM read data (valid the cycle after a read)
//           o_eligible       - this port may be granted a new read this cycle
//           o_rvalid/o_rdata - response to the consumer
module im_resp_skid
   import im_arb_pkg::*;
#(
   parameter int DATA_W = IM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_issue,
   input  logic              i_rready,
   input  logic [DATA_W-1:0] i_sram_rdata,
   output logic              o_eligible,
   output logic              o_rvalid,
   output logic [DATA_W-1:0] o_rdata
);

   logic              r_inflight;
   logic              r_held;
   logic [DATA_W-1:0] r_hold_data;
   logic              w_rvalid;

   // Only one response may be outstanding beyond the one being consumed now,
   // so the SRAM never has to stall for a full skid register.
   assign o_eligible = !r_held && (!r_inflight || i_rready);

   // A flush kills whatever is pending for this cycle; outputs stay quiet in reset.
   assign w_rvalid = !rst && !i_flush && (r_held || r_inflight);
   assign o_rvalid = w_rvalid;
   assign o_rdata  = !w_rvalid ? '0 : (r_held ? r_hold_data : i_sram_rdata);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight  <= 1'b0;
         r_held      <= 1'b0;
         r_hold_data <= '0;
      end else if (i_flush) begin
         // The redirect target granted in the flush cycle survives.
         r_inflight <= i_issue;
         r_held     <= 1'b0;
      end else begin
         r_inflight <= i_issue;
         if (r_inflight && !i_rready) begin
            r_held      <= 1'b1;
            r_hold_data <= i_sram_rdata;
         end else if (r_held && i_rready) begin
            r_held <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/im_port_arbiter.sv
// rtl/im_port_arbiter.sv - fetch/data arbiter for a single-port instruction SRAM
//
// Purpose : grants one of fetch (read-only) or load/store (read/write) per cycle,
//           fetch first unless data has lost STARVE_LIMIT cycles in a row, and
//           steers 1-cycle-latency read data back through per-port skid holds.
// Ports   : clk, rst                               - clock, sync active-high reset
//           f_req/f_addr/f_gnt                     - fetch request and grant
//           f_rvalid/f_rdata/f_rready, flush       - fetch response, redirect kill
//           d_req/d_we/d_addr/d_wdata/d_wstrb/d_gnt - data request and grant
//           d_rvalid/d_rdata/d_rready              - data read response
//           im_cs/im_we/im_addr/im_wdata/im_wstrb/im_rdata - SRAM macro side
//           perf_f_gnt/perf_d_gnt/perf_conflict    - only with IM_ARB_PERF_EN
// Options : IM_ARB_PERF_EN adds saturating grant/conflict counters.
module im_port_arbiter
   import im_arb_pkg::*;
#(
   parameter int ADDR_W       = IM_ADDR_W,
   parameter int DATA_W       = IM_DATA_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                f_req,
   input  logic [ADDR_W-1:0]   f_addr,
   output logic                f_gnt,
   output logic                f_rvalid,
   output logic [DATA_W-1:0]   f_rdata,
   input  logic                f_rready,
   input  logic                flush,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_wstrb,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [DATA_W-1:0]   d_rdata,
   input  logic                d_rready,
`ifdef IM_ARB_PERF_EN
   output logic [31:0]         perf_f_gnt,
   output logic [31:0]         perf_d_gnt,
   output logic [31:0]         perf_conflict,
`endif
   output logic                im_cs,
   output logic                im_we,
   output logic [ADDR_W-1:0]   im_addr,
   output logic [DATA_W-1:0]   im_wdata,
   output logic [DATA_W/8-1:0] im_wstrb,
   input  logic [DATA_W-1:0]   im_rdata
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic          w_f_skid_ok;
   logic          w_d_skid_ok;
   logic          w_f_elig;
   logic          w_d_elig;
   logic          w_d_force;
   logic          w_f_gnt;
   logic          w_d_gnt;
   logic          w_any;
   port_id_e      w_winner;
   im_req_t       w_f_req;
   im_req_t       w_d_req;
   im_req_t       w_sel;
   logic [SW-1:0] r_starve;

   // Requests are ignored while reset is asserted so every output reads 0.
   assign w_f_elig  = !rst && f_req && w_f_skid_ok;
   assign w_d_elig  = !rst && d_req && (d_we || w_d_skid_ok);
   assign w_d_force = w_d_elig && (r_starve == STARVE_MAX);
   assign w_f_gnt   = w_f_elig && !w_d_force;
   assign w_d_gnt   = w_d_elig && !w_f_gnt;
   assign w_any     = w_f_gnt || w_d_gnt;
   assign w_winner  = w_d_gnt ? PORT_DATA : PORT_FETCH;

   assign f_gnt = w_f_gnt;
   assign d_gnt = w_d_gnt;

   assign w_f_req = '{addr: f_addr, we: 1'b0, wdata: '0, wstrb: '0};
   assign w_d_req = '{addr: d_addr, we: d_we, wdata: d_wdata, wstrb: d_wstrb};

   always_comb begin
      w_sel = '0;
      if (w_any) begin
         w_sel = (w_winner == PORT_DATA) ? w_d_req : w_f_req;
      end
   end

   assign im_cs    = w_any;
   assign im_we    = w_sel.we;
   assign im_addr  = w_sel.addr;
   assign im_wdata = w_sel.wdata;
   assign im_wstrb = w_sel.wstrb;

   // Counts consecutive cycles an eligible data request lost to fetch; a data
   // request that is pending but not eligible neither advances nor clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve <= '0;
      end else if (!d_req || w_d_gnt) begin
         r_starve <= '0;
      end else if (w_d_elig && w_f_gnt && (r_starve != STARVE_MAX)) begin
         r_starve <= r_starve + SW'(1);
      end
   end

   im_resp_skid #(.DATA_W(DATA_W)) u_f_skid (
      .clk          (clk),
      .rst          (rst),
      .i_flush      (flush),
      .i_issue      (w_f_gnt),
      .i_rready     (f_rready),
      .i_sram_rdata (im_rdata),
      .o_eligible   (w_f_skid_ok),
      .o_rvalid     (f_rvalid),
      .o_rdata      (f_rdata)
   );

   // Writes return nothing, so only data reads occupy the data skid.
   im_resp_skid #(.DATA_W(DATA_W)) u_d_skid (
      .clk          (clk),
      .rst          (rst),
      .i_flush      (1'b0),
      .i_issue      (w_d_gnt && !d_we),
      .i_rready     (d_rready),
      .i_sram_rdata (im_rdata),
      .o_eligible   (w_d_skid_ok),
      .o_rvalid     (d_rvalid),
      .o_rdata      (d_rdata)
   );

`ifdef IM_ARB_PERF_EN
   logic [31:0] r_perf_f_gnt;
   logic [31:0] r_perf_d_gnt;
   logic [31:0] r_perf_conflict;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_f_gnt    <= '0;
         r_perf_d_gnt    <= '0;
         r_perf_conflict <= '0;
      end else begin
         if (w_f_gnt)              r_perf_f_gnt    <= sat_inc32(r_perf_f_gnt);
         if (w_d_gnt)              r_perf_d_gnt    <= sat_inc32(r_perf_d_gnt);
         if (w_f_elig && w_d_elig) r_perf_conflict <= sat_inc32(r_perf_conflict);
      end
   end

   assign perf_f_gnt    = r_perf_f_gnt;
   assign perf_d_gnt    = r_perf_d_gnt;
   assign perf_conflict = r_perf_conflict;
`endif

endmodule

// File: tb/tb_im_port_arbiter.sv
// tb/tb_im_port_arbiter.sv - self-checking bench for im_port_arbiter
module tb_im_port_arbiter;

   localparam int LIMIT = 4;

   logic        clk;
   logic        rst;
   logic        f_req, f_gnt, f_rvalid, f_rready, flush;
   logic [31:0] f_addr, f_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid, d_rready;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_wstrb;
   logic        im_cs, im_we;
   logic [31:0] im_addr, im_wdata, im_rdata;
   logic [3:0]  im_wstrb;

   im_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .f_rdata(f_rdata), .f_rready(f_rready), .flush(flush),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .d_rready(d_rready),
      .im_cs(im_cs), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .im_wstrb(im_wstrb), .im_rdata(im_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM macro: 256 words, 1-cycle read latency, byte-strobed writes.
   logic [31:0] sram [256];
   always @(posedge clk) begin
      if (im_cs) begin
         if (im_we) begin
            for (int b = 0; b < 4; b++)
               if (im_wstrb[b]) sram[im_addr[9:2]][8*b +: 8] <= im_wdata[8*b +: 8];
         end else begin
            im_rdata <= sram[im_addr[9:2]];
         end
      end
   end

   typedef struct {
      logic        rst, f_req;
      logic [31:0] f_addr;
      logic        f_rready, flush, d_req, d_we;
      logic [31:0] d_addr, d_wdata;
      logic [3:0]  d_wstrb;
      logic        d_rready;
      logic        x_f_gnt, x_d_gnt, x_f_rvalid;
      logic [31:0] x_f_rdata;
      logic        x_d_rvalid;
      logic [31:0] x_d_rdata;
   } vec_t;

   // Reference model: each port keeps a queue of responses owed to its consumer;
   // 'fresh' marks a response whose read was issued in the previous cycle.
   typedef struct {
      logic [31:0] data;
      bit          fresh;
   } resp_t;

   resp_t       fq[$];
   resp_t       dq[$];
   int          starve;
   logic [31:0] ref_mem [256];
   int          n_chk;
   int          n_fail;

   function automatic logic [31:0] memval(input int idx);
      return 32'h1234_5678 ^ (32'(idx) * 32'h0101_0111);
   endfunction

   function automatic vec_t mk(input bit r, input bit fr, input logic [31:0] fa, input bit frr,
                               input bit fl, input bit dr, input bit dw, input logic [31:0] da,
                               input logic [31:0] dwd, input logic [3:0] ds, input bit drr,
                               input bit xfg, input bit xdg, input bit xfv, input logic [31:0] xfd,
                               input bit xdv, input logic [31:0] xdd);
      vec_t v;
      v.rst = r; v.f_req = fr; v.f_addr = fa; v.f_rready = frr; v.flush = fl;
      v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dwd; v.d_wstrb = ds;
      v.d_rready = drr; v.x_f_gnt = xfg; v.x_d_gnt = xdg; v.x_f_rvalid = xfv;
      v.x_f_rdata = xfd; v.x_d_rvalid = xdv; v.x_d_rdata = xdd;
      return v;
   endfunction

   function automatic vec_t idle(input bit xfv, input logic [31:0] xfd,
                                 input bit xdv, input logic [31:0] xdd);
      return mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, xfv, xfd, xdv, xdd);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Applies one cycle of inputs, checks outputs against the model (and the
   // row's own expectations when use_x), then advances the model past the edge.
   task automatic step(input vec_t v, input bit use_x, input int row);
      bit          fv, dv, f_ok, d_ok, f_el, d_el, fwin, dwin;
      logic [31:0] fd, dd, ea, ewd;
      logic [3:0]  es;
      int          fi, di;
      rst = v.rst; f_req = v.f_req; f_addr = v.f_addr; f_rready = v.f_rready;
      flush = v.flush; d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr;
      d_wdata = v.d_wdata; d_wstrb = v.d_wstrb; d_rready = v.d_rready;
      #1;
      fi = int'(v.f_addr[9:2]);
      di = int'(v.d_addr[9:2]);
      fv = 0; dv = 0; fd = 0; dd = 0; fwin = 0; dwin = 0; d_el = 0;
      if (!v.rst) begin
         fv = (fq.size() > 0) && !v.flush;
         dv = (dq.size() > 0);
         if (fv) fd = fq[0].data;
         if (dv) dd = dq[0].data;
         f_ok = (fq.size() == 0) || (fq[0].fresh && v.f_rready);
         d_ok = (dq.size() == 0) || (dq[0].fresh && v.d_rready);
         f_el = v.f_req && f_ok;
         d_el = v.d_req && (v.d_we || d_ok);
         dwin = d_el && ((starve == LIMIT) || !f_el);
         fwin = f_el && !dwin;
      end
      ea  = fwin ? v.f_addr : (dwin ? v.d_addr : 32'd0);
      ewd = dwin ? v.d_wdata : 32'd0;
      es  = dwin ? v.d_wstrb : 4'd0;
      chk($sformatf("r%0d f_gnt", row), 32'(f_gnt), 32'(fwin));
      chk($sformatf("r%0d d_gnt", row), 32'(d_gnt), 32'(dwin));
      chk($sformatf("r%0d f_rvalid", row), 32'(f_rvalid), 32'(fv));
      chk($sformatf("r%0d f_rdata", row), f_rdata, fd);
      chk($sformatf("r%0d d_rvalid", row), 32'(d_rvalid), 32'(dv));
      chk($sformatf("r%0d d_rdata", row), d_rdata, dd);
      chk($sformatf("r%0d im_cs", row), 32'(im_cs), 32'(fwin || dwin));
      chk($sformatf("r%0d im_we", row), 32'(im_we), 32'(dwin && v.d_we));
      chk($sformatf("r%0d im_addr", row), im_addr, ea);
      chk($sformatf("r%0d im_wdata", row), im_wdata, ewd);
      chk($sformatf("r%0d im_wstrb", row), 32'(im_wstrb), 32'(es));
      if (use_x) begin
         chk($sformatf("vec%0d x_f_gnt", row), 32'(f_gnt), 32'(v.x_f_gnt));
         chk($sformatf("vec%0d x_d_gnt", row), 32'(d_gnt), 32'(v.x_d_gnt));
         chk($sformatf("vec%0d x_f_rvalid", row), 32'(f_rvalid), 32'(v.x_f_rvalid));
         chk($sformatf("vec%0d x_f_rdata", row), f_rdata, v.x_f_rdata);
         chk($sformatf("vec%0d x_d_rvalid", row), 32'(d_rvalid), 32'(v.x_d_rvalid));
         chk($sformatf("vec%0d x_d_rdata", row), d_rdata, v.x_d_rdata);
      end
      if (v.rst) begin
         fq.delete();
         dq.delete();
         starve = 0;
      end else begin
         if (v.flush) fq.delete();
         else if (fv && v.f_rready) void'(fq.pop_front());
         foreach (fq[i]) fq[i].fresh = 0;
         if (fwin) fq.push_back('{ref_mem[fi], 1'b1});
         if (dv && v.d_rready) void'(dq.pop_front());
         foreach (dq[i]) dq[i].fresh = 0;
         if (dwin && !v.d_we) dq.push_back('{ref_mem[di], 1'b1});
         if (dwin && v.d_we)
            for (int b = 0; b < 4; b++)
               if (v.d_wstrb[b]) ref_mem[di][8*b +: 8] = v.d_wdata[8*b +: 8];
         if (!v.d_req || dwin) starve = 0;
         else if (d_el && fwin && starve < LIMIT) starve++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   vec_t tbl[$];
   vec_t rv;

   initial begin
      n_chk = 0; n_fail = 0; starve = 0;
      for (int i = 0; i < 256; i++) begin
         sram[i] = memval(i);
         ref_mem[i] = memval(i);
      end
      im_rdata = 0;
      rst = 1; f_req = 0; f_addr = 0; f_rready = 0; flush = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; d_rready = 0;

      // Fetch-only streaming 0x0, 0x4, 0x8.
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 'h0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 'h4, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, memval(0), 0, 0));
      tbl.push_back(mk(0, 1, 'h8, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, memval(1), 0, 0));
      tbl.push_back(idle(1, memval(2), 0, 0));
      tbl.push_back(idle(0, 0, 0, 0));
      // Conflict and starvation: fetch wins 4 cycles, data wins the 5th.
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 'hC, 1, 0, 1, 0, 'h100, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(0, 1, 'hC, 1, 0, 1, 0, 'h100, 0, 0, 1, 1, 0, 1, memval(3), 0, 0));
      tbl.push_back(mk(0, 1, 'hC, 1, 0, 1, 0, 'h100, 0, 0, 1, 0, 1, 1, memval(3), 0, 0));
      tbl.push_back(mk(0, 1, 'hC, 1, 0, 1, 0, 'h100, 0, 0, 1, 1, 0, 0, 0, 1, memval(64)));
      tbl.push_back(idle(1, memval(3), 0, 0));
      tbl.push_back(idle(0, 0, 0, 0));
      // Back-pressure: read 0x10 held for 3 cycles.
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 'h10, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(0, 1, 'h14, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, memval(4), 0, 0));
      tbl.push_back(mk(0, 1, 'h14, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, memval(4), 0, 0));
      tbl.push_back(mk(0, 1, 'h14, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(idle(1, memval(5), 0, 0));
      tbl.push_back(idle(0, 0, 0, 0));
      // Flush with redirect to 0x80.
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 'h20, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 'h80, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(idle(1, memval(32), 0, 0));
      tbl.push_back(idle(0, 0, 0, 0));
      // Write then read 0x40.
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 'h40, 'hDEADBEEF, 'hF, 1, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 'h40, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      tbl.push_back(idle(0, 0, 1, 'hDEADBEEF));
      tbl.push_back(idle(0, 0, 0, 0));
      // Reset while data response is held.
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 'h44, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, memval(17)));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, memval(17)));
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(idle(0, 0, 0, 0));

      @(negedge clk);
      for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1, i);

      // Randomised traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         rv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         rv.rst      = ($urandom_range(0, 99) == 0);
         rv.f_req    = ($urandom_range(0, 3) != 0);
         rv.f_addr   = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         rv.f_rready = ($urandom_range(0, 9) < 7);
         rv.flush    = ($urandom_range(0, 7) == 0);
         rv.d_req    = ($urandom_range(0, 9) < 6);
         rv.d_we     = ($urandom_range(0, 2) == 0);
         rv.d_addr   = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         rv.d_wdata  = $urandom;
         rv.d_wstrb  = 4'($urandom_range(0, 15));
         rv.d_rready = ($urandom_range(0, 9) < 7);
         step(rv, 1'b0, 1000 + c);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/im_port_arbiter.md
Name: im_port_arbiter

Overview:
- Shares one synchronous single-port instruction SRAM between two requesters: the fetch front end (read-only) and the load/store unit (read/write data access to instruction space).
- Sits between the IF stage and the IM macro.
- Arbitrates per cycle and steers the 1-cycle-latency read data back to its owner.
- Gives each port a 1-entry skid hold so back-pressure never stalls the SRAM, and kills stale fetch data on a redirect flush.

Parameters:
- ADDR_W, 32, address width for both ports and the SRAM.
- DATA_W, 32, data width; the strobe width is DATA_W/8.
- STARVE_LIMIT, 4, number of consecutive cycles data may lose to fetch before data is forced to win (minimum 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch read request
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  DATA_W  fetch read data
- f_rready  in  1  fetch consumer accepts data
- flush  in  1  redirect (mispredict); kills older fetch responses
- d_req  in  1  data request
- d_we  in  1  data write (1) / read (0)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_wstrb  in  DATA_W/8  byte write enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid
- d_rdata  out  DATA_W  data read data
- d_rready  in  1  data consumer accepts data
- im_cs  out  1  SRAM chip select
- im_we  out  1  SRAM write enable
- im_addr  out  ADDR_W  SRAM address
- im_wdata  out  DATA_W  SRAM write data
- im_wstrb  out  DATA_W/8  SRAM byte strobes
- im_rdata  in  DATA_W  SRAM read data; valid the cycle after a read with im_cs=1

Behaviour:
- Reset: clock clk; reset rst, synchronous, active-high. Clears inflight, held and starve state. All outputs are 0 during and after reset until a request arrives.
- Per-port state: inflight (read issued last cycle), held (data captured but not yet consumed), hold_data register.
- Read eligibility: a read is eligible iff !held && (!inflight || rready). Writes are eligible whenever d_req=1.
- Grant timing:
  - Grant is combinational in the same cycle as the request.
  - The winner drives im_cs=1 plus its address, data and strobes. Fetch always drives im_we=0 and im_wstrb=0.
  - At most one grant per cycle.
- Arbitration:
  - Fetch has fixed priority over data.
  - Exception: when starve_cnt==STARVE_LIMIT and data is eligible, data wins.
  - starve_cnt increments, saturating, when data is eligible and fetch wins. It clears on a data grant or when d_req=0.
- Read response:
  - rvalid = held | inflight. rdata = held ? hold_data : im_rdata.
  - If inflight && !rready, the next cycle captures im_rdata into hold_data and sets held.
  - held clears on rready.
  - The response is in order, with no reordering across ports.
  - Read latency is 1 cycle when rready=1.
- Writes: take one SRAM cycle and produce no response. A write is not blocked by a pending read hold.
- Flush:
  - In the flush cycle f_rvalid is forced to 0.
  - Fetch inflight and held are cleared at the clock edge.
  - A fetch request presented in the flush cycle (the redirect target) is still arbitrated normally, and its response is kept.
  - Flush has no effect on the data port.
- Simultaneous flush and f_rready: the flush wins and no data is delivered.
- No request, or no eligible request: im_cs=0, and im_addr/im_wdata/im_wstrb are 0.

Optional Feature:
- Macro: IM_ARB_PERF_EN.
- When defined, adds three 32-bit outputs, all cleared by rst and saturating at all-ones:
  - perf_f_gnt: count of fetch grants.
  - perf_d_gnt: count of data grants.
  - perf_conflict: count of cycles where both ports were eligible.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package im_arb_pkg holds:
  - the port-id enum (PORT_FETCH, PORT_DATA);
  - ADDR_W/DATA_W defaults;
  - the request struct (addr, we, wdata, wstrb).
- Sub-module im_resp_skid: one instance per port, containing the inflight/held/hold_data logic, with a flush input tied 0 on the data instance.

Test Plan:
- Fetch-only streaming: f_req=1 at addresses 0x0, 0x4, 0x8 with f_rready=1 -> f_gnt=1 every cycle, and f_rdata equals mem[0x0], mem[0x4], mem[0x8] on cycles 1, 2, 3.
- Conflict and starvation, STARVE_LIMIT=4: f_req and d_req (read 0x100) held high -> fetch wins cycles 0-3, d_gnt=1 on cycle 4, fetch wins again on cycle 5.
- Back-pressure: fetch read 0x10 with f_rready=0 for 3 cycles -> f_rvalid stays 1 with stable data, f_gnt=0 while held, and the next grant follows the cycle after f_rready=1.
- Flush: fetch 0x20 is inflight, then flush=1 with f_addr=0x80 -> no data returned for 0x20, f_gnt=1 for 0x80, and mem[0x80] is returned next cycle.
- Write then read: data write 0xDEADBEEF, wstrb=0xF, to 0x40, then data read 0x40 -> d_rvalid with 0xDEADBEEF, and no response for the write.
- Reset mid-operation: assert rst while data is held -> the next cycle has all valid/gnt outputs at 0 and no spurious data after reset release.
